// File: rtl/latch_counter_unit.sv
// Load/clear data register plus a modulo up-counter with a programmable terminal value.
// Optional macro LATCH_COUNTER_SATURATE_EN makes the counter hold at CNT_MAX instead of wrapping.
module latch_counter_unit #(
    parameter int unsigned         LATCH_W = 8,
    parameter int unsigned         CNT_W   = 4,
    parameter logic [CNT_W-1:0]    CNT_MAX = {CNT_W{1'b1}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LATCH_W-1:0] d_in,
    input  logic               latch_set,
    input  logic               latch_clr,
    output logic [LATCH_W-1:0] q_out,
    input  logic               cnt_en,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   count,
    output logic               cnt_at_max
);

    logic [LATCH_W-1:0] q_d, q_q;
    logic [CNT_W-1:0]   count_d, count_q;
    logic               at_max;

    // Terminal compare stays at CNT_W bits so a full 2^CNT_W range cannot overflow.
    assign at_max = (count_q == CNT_MAX);

    // Latch: clear beats set, otherwise hold.
    always_comb begin
        q_d = q_q;
        if (latch_clr) begin
            q_d = '0;
        end else if (latch_set) begin
            q_d = d_in;
        end
    end

    // Counter: clear beats enable, otherwise hold.
    always_comb begin
        count_d = count_q;
        if (cnt_clr) begin
            count_d = '0;
        end else if (cnt_en) begin
            if (at_max) begin
`ifdef LATCH_COUNTER_SATURATE_EN
                count_d = CNT_MAX;
`else
                count_d = '0;
`endif
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_q     <= '0;
            count_q <= '0;
        end else begin
            q_q     <= q_d;
            count_q <= count_d;
        end
    end

    assign q_out      = q_q;
    assign count      = count_q;
    assign cnt_at_max = at_max;

endmodule

// File: tb/tb_latch_counter_unit.sv
// Self-checking bench: directed vector table, full-range wrap sequence, and random stimulus
// against a behavioural model. Unit A uses CNT_MAX=9, unit B the default terminal value.
module tb_latch_counter_unit;

    localparam int MAX_A = 9;
    localparam int MAX_B = 15;

    logic       clk;
    logic       rst;
    logic [7:0] d_in;
    logic       latch_set, latch_clr, cnt_en, cnt_clr;
    logic [7:0] q_out, q_b;
    logic [3:0] count, count_b;
    logic       cnt_at_max, at_max_b;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef LATCH_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    latch_counter_unit #(
        .LATCH_W (8),
        .CNT_W   (4),
        .CNT_MAX (4'd9)
    ) dut_a (
        .clk        (clk),
        .rst        (rst),
        .d_in       (d_in),
        .latch_set  (latch_set),
        .latch_clr  (latch_clr),
        .q_out      (q_out),
        .cnt_en     (cnt_en),
        .cnt_clr    (cnt_clr),
        .count      (count),
        .cnt_at_max (cnt_at_max)
    );

    latch_counter_unit #(
        .LATCH_W (8),
        .CNT_W   (4)
    ) dut_b (
        .clk        (clk),
        .rst        (rst),
        .d_in       (d_in),
        .latch_set  (latch_set),
        .latch_clr  (latch_clr),
        .q_out      (q_b),
        .cnt_en     (cnt_en),
        .cnt_clr    (cnt_clr),
        .count      (count_b),
        .cnt_at_max (at_max_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] d;
        logic       set;
        logic       clr;
        logic       en;
        logic       cc;
        logic [7:0] eq;
        logic [3:0] ec;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic [7:0] d, input logic s,
                                input logic c, input logic e, input logic cc,
                                input logic [7:0] eq, input int ec);
        vec_t v;
        v.rst = r; v.d = d; v.set = s; v.clr = c; v.en = e; v.cc = cc;
        v.eq = eq; v.ec = 4'(ec);
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [7:0] d, input logic s, input logic c,
                         input logic e, input logic cc);
        rst = r; d_in = d; latch_set = s; latch_clr = c; cnt_en = e; cnt_clr = cc;
        @(posedge clk);
        #1;
    endtask

    // Reference next-count from the counting rules.
    function automatic int next_cnt(input int cur, input int mx, input logic r,
                                    input logic e, input logic cc);
        if (!r || cc) return 0;
        if (!e) return cur;
        if (cur == mx) return SAT ? mx : 0;
        return (cur + 1) % (mx + 1);
    endfunction

    int         exp_c;
    int         ma, mb;
    logic [7:0] mq;

    initial begin
        rst = 1'b0; d_in = '0; latch_set = 0; latch_clr = 0; cnt_en = 0; cnt_clr = 0;

        // Reset dominates set/enable for two edges
        add(0, 8'hA5, 1, 0, 1, 0, 8'h00, 0);
        add(0, 8'hA5, 1, 0, 1, 0, 8'h00, 0);
        // Load then hold while d_in changes
        add(1, 8'h3C, 1, 0, 0, 0, 8'h3C, 0);
        add(1, 8'hFF, 0, 0, 0, 0, 8'h3C, 0);
        // Clear beats set
        add(1, 8'h55, 1, 1, 0, 0, 8'h00, 0);
        // Count through terminal value 9
        for (int i = 1; i <= 12; i++) begin
            exp_c = SAT ? ((i > MAX_A) ? MAX_A : i) : (i % (MAX_A + 1));
            add(1, 8'h00, 0, 0, 1, 0, 8'h00, exp_c);
        end
        // Clear, then count up to 5
        add(1, 8'h00, 0, 0, 0, 1, 8'h00, 0);
        for (int i = 1; i <= 5; i++) add(1, 8'h00, 0, 0, 1, 0, 8'h00, i);
        // Clear beats enable, then hold
        add(1, 8'h00, 0, 0, 1, 1, 8'h00, 0);
        for (int i = 0; i < 3; i++) add(1, 8'h00, 0, 0, 0, 0, 8'h00, 0);
        // Simultaneous load and count, up to 7
        add(1, 8'h81, 1, 0, 1, 0, 8'h81, 1);
        for (int i = 2; i <= 7; i++) add(1, 8'h00, 0, 0, 1, 0, 8'h81, i);
        // Mid-operation reset, then resume
        add(0, 8'h00, 0, 0, 1, 0, 8'h00, 0);
        add(1, 8'h00, 0, 0, 1, 0, 8'h00, 1);
        add(1, 8'h00, 0, 0, 1, 0, 8'h00, 2);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].d, vecs[i].set, vecs[i].clr, vecs[i].en, vecs[i].cc);
            chk($sformatf("vec%0d q_out", i), q_out, vecs[i].eq);
            chk($sformatf("vec%0d count", i), count, vecs[i].ec);
            chk($sformatf("vec%0d at_max", i), cnt_at_max, vecs[i].ec == 4'(MAX_A));
        end

        // Full 2^CNT_W range on the default-terminal unit
        drive(1, 8'h00, 0, 0, 0, 1);
        chk("b clear", count_b, 0);
        for (int i = 1; i <= 17; i++) begin
            drive(1, 8'h00, 0, 0, 1, 0);
            exp_c = SAT ? ((i > MAX_B) ? MAX_B : i) : (i % (MAX_B + 1));
            chk($sformatf("b wrap%0d count", i), count_b, exp_c);
            chk($sformatf("b wrap%0d at_max", i), at_max_b, exp_c == MAX_B);
        end

        // Random stimulus against the model
        drive(0, 8'h00, 0, 0, 0, 0);
        mq = 8'h00; ma = 0; mb = 0;
        for (int n = 0; n < 400; n++) begin
            logic       r, s, c, e, cc;
            logic [7:0] d;
            r  = ($urandom_range(0, 24) != 0);
            d  = 8'($urandom);
            s  = ($urandom_range(0, 3) == 0);
            c  = ($urandom_range(0, 7) == 0);
            e  = ($urandom_range(0, 3) != 0);
            cc = ($urandom_range(0, 15) == 0);
            if (!r || c) mq = 8'h00;
            else if (s) mq = d;
            ma = next_cnt(ma, MAX_A, r, e, cc);
            mb = next_cnt(mb, MAX_B, r, e, cc);
            drive(r, d, s, c, e, cc);
            chk("rnd q_out", q_out, mq);
            chk("rnd count_a", count, ma);
            chk("rnd at_max_a", cnt_at_max, ma == MAX_A);
            chk("rnd count_b", count_b, mb);
            chk("rnd at_max_b", at_max_b, mb == MAX_B);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
